// File: rtl/mem_pkg.sv
// Types shared by the data cache and its memory responder so both ends agree on
// byte order (element [0] is the most significant byte of the word).
package mem_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t mem_word_t [0:3];

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  localparam int MEM_LATENCY_DEFAULT = 4;

endpackage : mem_pkg

// File: rtl/data_memory_responder.sv
// Big-endian byte-addressed backing store answering cache word requests after LATENCY cycles.
// Latency: accept at edge k, mem_ready high k+LATENCY..k+LATENCY+1; requests ignored while busy.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_input,
  input  logic [7:0]  mem_data_in [0:3],
  input  logic        write_en,
  input  logic        mem_req,
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_busy,
  output logic        mem_ready
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  mem_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic                  we_q, we_d;
  mem_word_t             wdat_q, wdat_d;
  mem_word_t             rdat_q, rdat_d;
  mem_word_t             rd_word;
  logic                  accept;
  logic                  commit;
  logic                  unused_addr_bits;

  // Storage is deliberately outside the reset domain: reset only aborts the FSM.
  byte_t                 mem_q [0:DEPTH-1];

  // Only [ADDR_BITS-1:2] select storage; the remaining bits alias by design.
  assign unused_addr_bits = ^address_input;

  assign accept = mem_req && ((state_q == MEM_IDLE) || (state_q == MEM_RESP));
  assign commit = (state_q == MEM_BUSY) && (cnt_q == 4'd0);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_word[i] = mem_q[{addr_q[ADDR_BITS-1:2], 2'(i)}];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;

    case (state_q)
      MEM_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = MEM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase

    // RESP doubles as an accept slot so a held request streams every LATENCY+1 cycles.
    if (accept) begin
      state_d = MEM_BUSY;
      cnt_d   = 4'(LATENCY - 1);
      addr_d  = {address_input[ADDR_BITS-1:2], 2'b00};
      we_d    = write_en;
      wdat_d  = mem_data_in;
    end

    if (commit && !we_q) begin
      rdat_d = rd_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '{default: '0};
      rdat_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[{addr_q[ADDR_BITS-1:2], 2'(i)}] <= wdat_q[i];
      end
    end
  end

  assign mem_data_out = rdat_q;
  assign mem_busy     = (state_q != MEM_IDLE);
  assign mem_ready    = (state_q == MEM_RESP);

endmodule : data_memory_responder
